// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler and its ALU environment.
package alu_sched_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_DEPTH = 3;
    localparam int FLAG_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester closest above last_grant (with wrap) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int w_best_dist;
    int w_dist;

    // Distance 0 is the slot just after last_grant, so it carries top priority.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        w_best_dist = NUM_REQ;
        w_dist      = 0;
        if (enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_dist = (i - int'(last_grant) - 1 + NUM_REQ) % NUM_REQ;
                if (req[i] && (w_dist < w_best_dist)) begin
                    w_best_dist = w_dist;
                    grant       = '0;
                    grant[i]    = 1'b1;
                    grant_idx   = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between NUM_REQ requesters,
// returning each result on a single ID-tagged valid/ready response channel.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int DEPTH   = ALU_DEPTH,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*DEPTH-1:0] req_op,
    output logic [WIDTH-1:0]         alu_operand_a,
    output logic [WIDTH-1:0]         alu_operand_b,
    output logic [DEPTH-1:0]         alu_opcode,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [FLAG_W-1:0]        rsp_flags,
    output logic                     busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [DEPTH-1:0]   r_alu_op;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_y;
    flags_t             r_rsp_flags;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [DEPTH-1:0]   w_sel_op;
    flags_t             w_alu_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .enable     (r_state == IDLE),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    assign w_accept    = (r_state == IDLE) && (|(req_valid & w_grant));
    assign w_alu_flags = '{carry: alu_carry, zero: alu_zero, overflow: alu_overflow};

    // One-hot grant selects the winning requester's operand slices.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = req_a[i*WIDTH +: WIDTH];
                w_sel_b  = req_b[i*WIDTH +: WIDTH];
                w_sel_op = req_op[i*DEPTH +: DEPTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_last_grant <= w_grant_idx;
        end
    end

    // ALU operand registers load on accept; the response is captured after the EXEC settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
                r_id     <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_rsp_y     <= alu_y;
                r_rsp_flags <= w_alu_flags;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready     = w_grant;
    assign alu_operand_a = r_alu_a;
    assign alu_operand_b = r_alu_b;
    assign alu_opcode    = r_alu_op;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_y         = r_rsp_y;
    assign rsp_flags     = r_rsp_flags;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed testbench for alu_req_scheduler with a small combinational ALU model (opcode 0 = ADD).
module tb_alu_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic [7:0]  alu_operand_a;
    logic [7:0]  alu_operand_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_y;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic [2:0]  rsp_flags;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_y [4];
    logic [1:0] exp_g;

    always #5 clk = ~clk;

    alu_req_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_opcode    (alu_opcode),
        .alu_y         (alu_y),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_y         (rsp_y),
        .rsp_flags     (rsp_flags),
        .busy          (busy)
    );

    logic [8:0] sum;
    assign sum = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};

    always_comb begin
        if (alu_opcode == 3'd0) begin
            alu_y        = sum[7:0];
            alu_carry    = sum[8];
            alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) && (sum[7] != alu_operand_a[7]);
        end else begin
            alu_y        = alu_operand_a ^ alu_operand_b;
            alu_carry    = 1'b0;
            alu_overflow = 1'b0;
        end
        alu_zero = (alu_y == 8'h00);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        do_reset();

        // Idle after reset: every output low for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            chk("idle_outputs", {busy, req_ready, rsp_valid, alu_operand_a, alu_operand_b,
                                 alu_opcode, rsp_id, rsp_y, rsp_flags}, 64'd0);
            tick();
        end

        // Requester 2 alone: F0 + 20 = 10 with carry.
        req_a[2*8 +: 8]  = 8'hF0;
        req_b[2*8 +: 8]  = 8'h20;
        req_op[2*3 +: 3] = 3'd0;
        req_valid        = 4'b0100;
        #1;
        chk("r2_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("r2_exec_ops", {alu_operand_a, alu_operand_b, alu_opcode}, {8'hF0, 8'h20, 3'd0});
        chk("r2_exec_ctl", {busy, rsp_valid, req_ready}, {1'b1, 1'b0, 4'b0000});
        tick();
        chk("r2_rsp", {rsp_valid, rsp_id, rsp_y, rsp_flags}, {1'b1, 2'd2, 8'h10, 3'b100});
        rsp_ready = 1'b1;
        tick();
        chk("r2_done", {rsp_valid, busy}, 2'b00);

        // Fairness: all four valid, rsp_ready high, grants 0,1,2,3,0,1 every 3 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8]  = 8'h10 * (i + 1);
            req_b[i*8 +: 8]  = 8'h01;
            req_op[i*3 +: 3] = 3'd0;
        end
        exp_y[0] = 8'h11;
        exp_y[1] = 8'h21;
        exp_y[2] = 8'h31;
        exp_y[3] = 8'h41;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_g = 2'(k % 4);
            chk("rr_ready", req_ready, 4'b0001 << exp_g);
            tick();
            tick();
            chk("rr_rsp", {rsp_valid, rsp_id, rsp_y, rsp_flags}, {1'b1, exp_g, exp_y[exp_g], 3'b000});
            tick();
            chk("rr_release", rsp_valid, 1'b0);
        end

        // Back-pressure with 80 + 80: result 0, all flags set, held for 5 stalled cycles.
        req_valid        = '0;
        rsp_ready        = 1'b0;
        req_a[0*8 +: 8]  = 8'h80;
        req_b[0*8 +: 8]  = 8'h80;
        req_valid        = 4'b0001;
        #1;
        chk("bp_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1111;
        chk("bp_exec_ready", req_ready, 4'b0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags},
                {4'b0000, 1'b1, 2'd0, 8'h00, 3'b111});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_done", {rsp_valid, busy}, 2'b00);
        chk("bp_next_ready", req_ready, 4'b0010);
        req_valid = '0;
        tick();
        chk("drop_idle", {busy, req_ready}, 5'b0_0000);

        // Reset during EXEC discards the op; pointer returns so requester 0 wins over 3.
        req_valid = 4'b0100;
        #1;
        chk("rst_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("rst_exec_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {busy, rsp_valid, alu_operand_a}, {1'b0, 1'b0, 8'h00});
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_rsp", {rsp_valid, busy}, 2'b00);
        end
        req_valid = 4'b1001;
        #1;
        chk("rst_prio0", req_ready, 4'b0001);
        tick();
        tick();
        chk("rst_rsp0", {rsp_valid, rsp_id, rsp_y, rsp_flags}, {1'b1, 2'd0, 8'h00, 3'b111});
        tick();
        chk("rst_ready3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("rst_rsp3", {rsp_valid, rsp_id, rsp_y, rsp_flags}, {1'b1, 2'd3, 8'h41, 3'b000});
        tick();
        chk("final_idle", {rsp_valid, busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational ALU between NUM_REQ requesters, each with its own valid/ready request channel.
- Grants requesters round-robin and drives registered operands/opcode to the ALU.
- Captures the result and flags one cycle later and returns them on a single valid/ready response channel tagged with the requester ID.
- Sits between the requester-side fabric and the ALU slave port: a, b and opcode out; y, carry, zero and overflow in.

Parameters:
- WIDTH, 8, operand/result width in bits
- DEPTH, 3, opcode width in bits
- NUM_REQ, 4, number of requesters (>=2)
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i
- req_b  in  NUM_REQ*WIDTH  packed operand B
- req_op  in  NUM_REQ*DEPTH  packed opcode
- alu_operand_a  out  WIDTH  registered operand A to ALU
- alu_operand_b  out  WIDTH  registered operand B to ALU
- alu_opcode  out  DEPTH  registered opcode to ALU
- alu_y  in  WIDTH  ALU result
- alu_carry  in  1  ALU carry
- alu_zero  in  1  ALU zero
- alu_overflow  in  1  ALU overflow
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that issued the op
- rsp_y  out  WIDTH  captured result
- rsp_flags  out  3  {carry, zero, overflow} captured
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE; alu_operand_a/b=0; alu_opcode=0; rsp_valid=0; rsp_id=0; rsp_y=0; rsp_flags=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = first asserted req_valid searching from last_grant+1 upward, with modulo NUM_REQ wrap.
  - req_ready = grant, combinational, with at most one bit set; req_ready is all-zero in every other state.
  - On the edge where req_valid[g]&req_ready[g]: load alu_operand_a/b/opcode from slice g, store g in id register, last_grant<=g, state<=EXEC.
  - No valid request: stay IDLE, outputs hold.
- EXEC: exactly one cycle; the ALU settles. Next edge:
  - rsp_y<=alu_y; rsp_flags<={alu_carry,alu_zero,alu_overflow}; rsp_id<=id; rsp_valid<=1; state<=RESP.
- RESP:
  - rsp_valid stays high and all rsp_* stay stable until rsp_ready is sampled high.
  - On that edge: rsp_valid<=0, state<=IDLE.
  - rsp_ready may be high before rsp_valid; the transfer completes on the first edge where both are high.
- ALU outputs (alu_operand_a/b/opcode) hold their last values outside EXEC and are never reset mid-op except by rst_n.
- Latency: accept edge E0 -> rsp_valid high after E1 (2 edges). Minimum issue interval is 3 cycles when rsp_ready is held high.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,… A requester waits at most NUM_REQ-1 grants.
- Dropping req_valid before the grant is legal and loses nothing. Requests are not accepted while busy.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is discarded and no response is produced. last_grant returns to NUM_REQ-1.
- No arithmetic is done here; widths pass through unchanged.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum (IDLE, EXEC, RESP), 2 bits;
  - flags struct {carry, zero, overflow} and the FLAG_W=3 constant;
  - default WIDTH/DEPTH constants shared with the ALU environment.
- Sub-module rr_arbiter (params NUM_REQ):
  - inputs: req vector, last_grant pointer, enable;
  - outputs: one-hot grant and encoded index.
  - Combinational only; the pointer register lives in alu_req_scheduler.

Test Plan (bench ALU model: opcode 3'd0=ADD):
- Reset release, no requests -> busy=0, req_ready=0, rsp_valid=0, all outputs 0 for 10 cycles.
- Requester 2 alone: a=8'hF0, b=8'h20, op=0 -> req_ready[2] in the same cycle; alu_operand_a=F0 after E0; rsp_valid after E1 with rsp_id=2, rsp_y=8'h10, rsp_flags carry=1, zero=0.
- All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. Each response 3 cycles apart with matching rsp_id.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable for 5 cycles; req_ready stays 0 throughout; completes on the first high rsp_ready.
- a=8'h80, b=8'h80, op=0 -> rsp_y=0, zero=1, carry=1, overflow=1.
- rst_n pulsed low during EXEC -> rsp_valid never asserts for that op; the next request from requester 3 with requester 0 also valid grants 0 first.
